// File: rtl/shift_sequencer.sv
// Multi-cycle controller that drives a single-step SLL8 / SRA1 shifter to perform
// variable-length shifts, feeding the shifter output back into its input once per clock.
module shift_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned AMOUNT_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    shiftLeft,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  input  logic [WIDTH-1:0]        dataIn,
  output logic [1:0]              shiftControl,
  output logic [WIDTH-1:0]        shiftData,
  input  logic [WIDTH-1:0]        shiftResult,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result
);

  localparam logic [1:0] CtrlPass = 2'b00;
  localparam logic [1:0] CtrlSll8 = 2'b10;
  localparam logic [1:0] CtrlSra1 = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                  state_q;
  logic                    dir_q;
  logic [AMOUNT_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0]        acc_q;
  logic [AMOUNT_WIDTH-1:0] steps;

  // Left moves a byte per step, so the low three amount bits are dropped.
  always_comb begin
    steps = amount;
    if (shiftLeft) begin
      steps = amount >> 3;
    end
  end

  assign shiftData = acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      result       <= '0;
      shiftControl <= CtrlPass;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            acc_q <= dataIn;
            dir_q <= shiftLeft;
            cnt_q <= steps;
            busy  <= 1'b1;
            if (steps != '0) begin
              state_q      <= StShift;
              shiftControl <= shiftLeft ? CtrlSll8 : CtrlSra1;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
              result  <= dataIn;
            end
          end
        end
        StShift: begin
          acc_q <= shiftResult;
          cnt_q <= cnt_q - AMOUNT_WIDTH'(1);
          if (cnt_q == AMOUNT_WIDTH'(1)) begin
            // Last step: publish the shifter output directly so result is valid in DONE.
            state_q      <= StDone;
            shiftControl <= CtrlPass;
            done         <= 1'b1;
            result       <= shiftResult;
          end else begin
            shiftControl <= dir_q ? CtrlSll8 : CtrlSra1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          shiftControl <= CtrlPass;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer with an external one-step shifter model
// and an arithmetic reference for the final word and latency.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        shiftLeft;
  logic [4:0]  amount;
  logic [31:0] dataIn;
  logic [1:0]  shiftControl;
  logic [31:0] shiftData;
  logic [31:0] shiftResult;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer #(
    .WIDTH       (32),
    .AMOUNT_WIDTH(5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .shiftLeft   (shiftLeft),
    .amount      (amount),
    .dataIn      (dataIn),
    .shiftControl(shiftControl),
    .shiftData   (shiftData),
    .shiftResult (shiftResult),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // MIC-1 shifter: 10 = SLL8, 01 = SRA1, otherwise pass.
  assign shiftResult = (shiftControl == 2'b10) ? (shiftData << 8) :
                       (shiftControl == 2'b01) ? {shiftData[31], shiftData[31:1]} : shiftData;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic left,
                                            input logic [4:0] amt);
    logic signed [31:0] s;
    int                 bytes;
    s     = d;
    bytes = int'(amt) / 8;
    if (left) return d << (8 * bytes);
    return s >>> amt;
  endfunction

  function automatic int ref_steps(input logic left, input logic [4:0] amt);
    return left ? int'(amt) / 8 : int'(amt);
  endfunction

  task automatic run_cmd(input logic [31:0] d, input logic left, input logic [4:0] amt,
                         input bit collide);
    logic [31:0] exp_r;
    logic [1:0]  code;
    int          n_exp;
    int          nshift;
    int          done_cyc;
    bit          bad_code;
    exp_r    = ref_shift(d, left, amt);
    n_exp    = ref_steps(left, amt);
    code     = left ? 2'b10 : 2'b01;
    nshift   = 0;
    done_cyc = 0;
    bad_code = 0;
    @(negedge clock);
    start = 1'b1; dataIn = d; shiftLeft = left; amount = amt;
    @(negedge clock);
    start = 1'b0; dataIn = $urandom; shiftLeft = ~left; amount = 5'($urandom);
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clock);
      if (shiftControl != 2'b00) begin
        nshift++;
        if (shiftControl != code) bad_code = 1;
      end
      if (done) begin
        done_cyc = i;
        break;
      end
      if (collide && i == 3) begin
        start = 1'b1; dataIn = ~d; shiftLeft = ~left; amount = 5'd1;
      end else if (collide && i == 4) begin
        start = 1'b0;
      end
    end
    check("done_cycle", done_cyc, n_exp + 1);
    check("shift_cycles", nshift, n_exp);
    check("shift_code", bad_code, 0);
    check("result", result, exp_r);
    check("busy_in_done", busy, 1);
    if (collide) begin
      start = 1'b1; dataIn = ~d; shiftLeft = left; amount = 5'd0;
    end
    @(negedge clock);
    start = 1'b0;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("result_held", result, exp_r);
  endtask

  initial begin
    int n_done;
    reset = 1'b1; start = 1'b0; shiftLeft = 1'b0; amount = '0; dataIn = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ctrl", shiftControl, 0);
    check("rst_data", shiftData, 0);
    reset = 1'b0;

    run_cmd(32'h8000_0000, 1'b0, 5'd4, 0);
    run_cmd(32'h0000_00AB, 1'b1, 5'd16, 0);
    run_cmd(32'h1234_5678, 1'b1, 5'd31, 0);
    run_cmd(32'hDEAD_BEEF, 1'b0, 5'd0, 0);
    run_cmd(32'hDEAD_BEEF, 1'b1, 5'd0, 0);
    run_cmd(32'h7FFF_FFFF, 1'b0, 5'd31, 0);
    run_cmd(32'h8000_0001, 1'b0, 5'd31, 0);
    run_cmd(32'hC3A5_0F0F, 1'b0, 5'd8, 1);

    // Reset in the middle of a long right shift.
    @(negedge clock);
    start = 1'b1; dataIn = 32'h9ABC_DEF0; shiftLeft = 1'b0; amount = 5'd20;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_ctrl", shiftControl, 0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_cmd(32'h0F0F_F0F0, 1'b0, 5'd3, 0);

    // Reset and start together: the command is dropped.
    @(negedge clock);
    reset = 1'b1; start = 1'b1; dataIn = 32'h1111_2222; shiftLeft = 1'b1; amount = 5'd8;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    check("rststart_busy", busy, 0);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("rststart_no_done", n_done, 0);
    check("rststart_result", result, 0);

    for (int t = 0; t < 25; t++) begin
      run_cmd($urandom, 1'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the single-step MIC-1 shifter (SLL8 / SRA1) to perform variable-length shifts.
- Accepts a command (data, direction, amount), then iterates the external combinational shifter once per clock, feeding its output back as the next input.
- Returns the final word with a one-cycle done pulse.
- Sits between the control unit and the shifter.

Parameters:
- WIDTH, 32, data word width; must match the shifter.
- AMOUNT_WIDTH, 5, width of the shift-amount field.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- shiftLeft  input  1  1 = left (SLL8 steps), 0 = right (SRA1 steps)
- amount  input  AMOUNT_WIDTH  shift distance in bits
- dataIn  input  WIDTH  operand latched on accepted start
- shiftControl  output  2  drives shifter control: 2'b00 pass, 2'b10 SLL8, 2'b01 SRA1
- shiftData  output  WIDTH  drives shifter data input
- shiftResult  input  WIDTH  shifter dataOut; combinational from shiftControl/shiftData
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  final shifted word; held until the next accepted start or reset

Behaviour:
- Reset values:
  - state = IDLE.
  - acc, result, shiftData = 0.
  - shiftControl = 2'b00.
  - busy = 0, done = 0, step counter = 0.
- Step count N:
  - Left: N = amount[4:3] (0..3). amount[2:0] is ignored, so the left distance is rounded down to a multiple of 8.
  - Right: N = amount (0..31).
- States:
  - IDLE:
    - shiftControl = 00; shiftData = acc.
    - start = 1: latch acc <= dataIn, dir <= shiftLeft, cnt <= N.
    - Next state is SHIFT if N != 0, else DONE.
  - SHIFT:
    - shiftData = acc; shiftControl = 2'b10 if dir, else 2'b01.
    - Each cycle: acc <= shiftResult, cnt <= cnt - 1.
    - When cnt == 1 at the edge, next state is DONE.
  - DONE:
    - shiftControl = 00; done = 1; result <= acc (registered, visible from this cycle); busy = 1.
    - Next state is IDLE unconditionally.
- Latency:
  - start sampled at edge k; SHIFT occupies cycles k+1 .. k+N; done = 1 in cycle k+N+1.
  - N = 0 gives done in cycle k+1 with result = dataIn.
  - Throughput: one command per N+2 cycles.
- Handshake:
  - start is ignored while busy, including the DONE cycle.
  - Command inputs need only be valid in the start cycle.
- Arithmetic:
  - SRA1 replicates bit 31 (sign fill).
  - SLL8 fills zeros.
  - No saturation; 3 left steps leave only the low byte in the top position.
- Reset mid-operation: abort immediately; all outputs return to reset values next cycle; no done pulse.
- Reset and start in the same cycle: reset wins; the command is dropped.
- result does not change in IDLE, SHIFT, or on ignored starts.

Test Plan:
- Right shift: dataIn = 0x80000000, shiftLeft = 0, amount = 4 → shiftControl = 01 for 4 cycles, done at k+5, result = 0xF8000000.
- Left shift: dataIn = 0x000000AB, shiftLeft = 1, amount = 16 → 2 SLL8 steps, done at k+3, result = 0x00AB0000. Repeat with amount = 31 and dataIn = 0x12345678 → 3 steps, result = 0x78000000.
- Zero amount: dataIn = 0xDEADBEEF, amount = 0 (both directions) → no SHIFT cycles, shiftControl stays 00, done at k+1, result = 0xDEADBEEF.
- Full right: dataIn = 0x7FFFFFFF, amount = 31 → result = 0x00000000, done at k+32. dataIn = 0x80000001, amount = 31 → result = 0xFFFFFFFF.
- Busy collision: start a right shift of 8, pulse start again with different data at k+3 and at the DONE cycle → both ignored, single done, result matches the first command.
- Reset mid-op: start a right shift of 20, assert reset at k+5 for 1 cycle → busy = 0, done never pulses, result = 0. A new command then completes correctly.
